gcd_host: RTL and testbench

Host-side sequencer for the `gcd` core: the initiator end of the core's load/valid interface. Operands arrive as a nibble stream on a narrow valid/ready pin interface and are assembled into two WIDTH-bit operands. The block pulses `gcd_loadingValues`, waits for `gcd_outputValid`, latches the result and streams it back out as nibbles. It sits between the TinyTapeout pin wrapper and `gcd`, so the core can be exercised with full-width operands despite only 8 I/O pins.

---
 rtl/gcd_host.sv | 135 +++++++++++++
 tb/tb_gcd_host.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_host.sv
// Host-side sequencer for the gcd core: assembles two nibble-streamed operands,
// pulses the core's load, waits for its result and streams it back as nibbles.
module gcd_host #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_nibble,
    output logic             in_ready,
    output logic             out_valid,
    output logic [3:0]       out_nibble,
    input  logic             out_ready,
    output logic             busy,
    output logic             timeout,
    output logic [WIDTH-1:0] gcd_value1,
    output logic [WIDTH-1:0] gcd_value2,
    output logic             gcd_loadingValues,
    input  logic [WIDTH-1:0] gcd_outputGCD,
    input  logic             gcd_outputValid
);
    localparam int NIBS = WIDTH / 4;
    localparam int NW   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NW-1:0] LAST_NIB  = NW'(NIBS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_COLLECT_A,
        S_COLLECT_B,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_result;
    logic [NW-1:0]     r_nib_cnt;
    logic [TW-1:0]     r_tick_cnt;
    logic              r_timeout;

    logic w_collect;
    logic w_in_fire;
    logic w_out_fire;
    logic w_last_nib;
    logic w_tick_hit;

    // Handshake outputs come from registered state only; reset just gates in_ready.
    assign w_collect  = (r_state == S_COLLECT_A) || (r_state == S_COLLECT_B);
    assign in_ready   = w_collect && !reset;
    assign out_valid  = (r_state == S_DRAIN);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_last_nib = (r_nib_cnt == LAST_NIB);
    assign w_tick_hit = (r_tick_cnt == LAST_TICK);

    assign out_nibble = r_result[WIDTH-1 -: 4];
    assign gcd_value1 = r_a;
    assign gcd_value2 = r_b;
    assign timeout    = r_timeout;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_COLLECT_A;
        else       r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next            = r_state;
        gcd_loadingValues = 1'b0;
        busy              = 1'b0;
        case (r_state)
            S_COLLECT_A: if (w_in_fire && w_last_nib) w_next = S_COLLECT_B;
            S_COLLECT_B: if (w_in_fire && w_last_nib) w_next = S_START;
            S_START: begin
                gcd_loadingValues = 1'b1;
                busy              = 1'b1;
                w_next            = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (gcd_outputValid || w_tick_hit) w_next = S_DRAIN;
            end
            S_DRAIN:     if (w_out_fire && w_last_nib) w_next = S_COLLECT_A;
            default:     w_next = S_COLLECT_A;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_nib_cnt  <= '0;
            r_tick_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT_A: if (w_in_fire) begin
                    r_a       <= {r_a[WIDTH-5:0], in_nibble};
                    r_nib_cnt <= w_last_nib ? '0 : r_nib_cnt + 1'b1;
                    r_timeout <= 1'b0;
                end
                S_COLLECT_B: if (w_in_fire) begin
                    r_b       <= {r_b[WIDTH-5:0], in_nibble};
                    r_nib_cnt <= w_last_nib ? '0 : r_nib_cnt + 1'b1;
                end
                S_START: r_tick_cnt <= '0;
                S_WAIT: begin
                    if (gcd_outputValid) begin
                        r_result <= gcd_outputGCD;
                    end else if (w_tick_hit) begin
                        // Abort: all-ones result plus the sticky flag tells the host.
                        r_result  <= '1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_DRAIN: if (w_out_fire) begin
                    r_result  <= {r_result[WIDTH-5:0], 4'h0};
                    r_nib_cnt <= w_last_nib ? '0 : r_nib_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_host.sv
// Self-checking bench for gcd_host: stub core with programmable latency,
// directed vector table, reset/back-to-back sequences and randomized operations.
module tb_gcd_host;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;
    localparam int NIBS    = WIDTH / 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          lat;     // core reports valid in WAIT cycle lat+1
        bit          gap;     // random idle cycles between input nibbles
        int          stall;   // output nibble index held back 5 cycles (-1 none)
        logic [15:0] exp_res;
        bit          exp_to;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_nibble = 4'h0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_nibble;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        timeout;
    logic [15:0] gcd_value1;
    logic [15:0] gcd_value2;
    logic        gcd_loadingValues;
    logic [15:0] gcd_outputGCD;
    logic        gcd_outputValid;

    gcd_host #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_nibble(in_nibble), .in_ready(in_ready),
        .out_valid(out_valid), .out_nibble(out_nibble), .out_ready(out_ready),
        .busy(busy), .timeout(timeout),
        .gcd_value1(gcd_value1), .gcd_value2(gcd_value2),
        .gcd_loadingValues(gcd_loadingValues),
        .gcd_outputGCD(gcd_outputGCD), .gcd_outputValid(gcd_outputValid)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] gcd_ref(input logic [15:0] x_in, input logic [15:0] y_in);
        logic [15:0] x = x_in;
        logic [15:0] y = y_in;
        logic [15:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Stub core: result is the true gcd, valid after a programmable delay.
    int          core_lat = 0;
    int          core_cnt = 0;
    logic [15:0] core_gcd = '0;
    always @(posedge clock) begin
        if (reset) begin
            core_cnt <= 0;
            core_gcd <= '0;
        end else if (gcd_loadingValues) begin
            core_cnt <= core_lat;
            core_gcd <= gcd_ref(gcd_value1, gcd_value2);
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
        end
    end
    assign gcd_outputValid = (core_cnt == 0);
    assign gcd_outputGCD   = core_gcd;

    int          load_cycles = 0;
    int          load_cyc = 0;
    logic [15:0] ld_v1 = '0;
    logic [15:0] ld_v2 = '0;
    always @(negedge clock) begin
        if (gcd_loadingValues) begin
            load_cycles++;
            load_cyc = cyc;
            ld_v1    = gcd_value1;
            ld_v2    = gcd_value2;
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int last_in_cyc = 0;
    int last_take_cyc = 0;
    bit prev_to = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit gaps, input string nm);
        logic [31:0] w;
        int guard;
        w = {a, b};
        for (int i = 0; i < 2 * NIBS; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            in_valid  = 1'b1;
            in_nibble = w[31 - 4 * i -: 4];
            guard = 0;
            while (!in_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) begin
                check({nm, ".in_ready_wait"}, 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                last_in_cyc = cyc;
                return;
            end
            tick();
            in_valid = 1'b0;
            if (i == 0) check({nm, ".to_clear"}, 32'(timeout), 32'd0);
        end
        last_in_cyc = cyc;
    endtask

    task automatic recv(input int stall, input string nm, output logic [15:0] res,
                        output int first_c, output logic to_seen);
        int guard;
        logic [3:0] hold;
        res = '0;
        first_c = -1;
        to_seen = 1'bx;
        out_ready = 1'b1;
        for (int i = 0; i < NIBS; i++) begin
            guard = 0;
            while (!out_valid && guard < 200) begin
                tick();
                guard++;
            end
            if (guard >= 200) begin
                check({nm, ".out_valid_wait"}, 32'(out_valid), 32'd1);
                return;
            end
            if (i == 0) begin
                first_c = cyc;
                to_seen = timeout;
            end
            if (i == stall) begin
                out_ready = 1'b0;
                hold = out_nibble;
                repeat (5) begin
                    tick();
                    check({nm, ".hold_nib"}, 32'(out_nibble), 32'(hold));
                    check({nm, ".hold_valid"}, 32'(out_valid), 32'd1);
                    check({nm, ".hold_in_ready"}, 32'(in_ready), 32'd0);
                end
                out_ready = 1'b1;
            end
            res = {res[11:0], out_nibble};
            tick();
        end
        last_take_cyc = cyc;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        logic [15:0] res;
        int first_c;
        logic to_seen;
        int k;
        check({nm, ".to_before"}, 32'(timeout), 32'(prev_to));
        load_cycles = 0;
        core_lat = v.lat;
        send(v.a, v.b, v.gap, nm);
        check({nm, ".in_ready_start"}, 32'(in_ready), 32'd0);
        recv(v.stall, nm, res, first_c, to_seen);
        check({nm, ".result"}, 32'(res), 32'(v.exp_res));
        check({nm, ".to_drain"}, 32'(to_seen), 32'(v.exp_to));
        check({nm, ".to_after"}, 32'(timeout), 32'(v.exp_to));
        // k = WAIT cycle that ends the wait: first valid, or the TIMEOUT-th cycle.
        k = (v.lat + 1 < TIMEOUT) ? v.lat + 1 : TIMEOUT;
        check({nm, ".latency"}, 32'(first_c - last_in_cyc), 32'(k + 1));
        check({nm, ".load_pulses"}, 32'(load_cycles), 32'd1);
        check({nm, ".load_edge"}, 32'(load_cyc), 32'(last_in_cyc));
        check({nm, ".value1"}, 32'(ld_v1), 32'(v.a));
        check({nm, ".value2"}, 32'(ld_v2), 32'(v.b));
        prev_to = v.exp_to;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];
    vec_t v;
    int   t_take;

    initial begin
        vecs[0] = '{16'h0030, 16'h0012, 4,  1'b0, -1, 16'h0006, 1'b0};
        vecs[1] = '{16'h0007, 16'h0000, 0,  1'b0, -1, 16'h0007, 1'b0};
        vecs[2] = '{16'h0021, 16'h000B, 2,  1'b1,  2, 16'h000B, 1'b0};
        vecs[3] = '{16'h1234, 16'h0056, 20, 1'b0, -1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h0100, 16'h0040, 7,  1'b0, -1, 16'h0040, 1'b0};
        vecs[5] = '{16'h0005, 16'h0003, 8,  1'b0,  0, 16'hFFFF, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 0,  1'b1, -1, 16'h0000, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 3,  1'b0,  3, 16'hFFFF, 1'b0};

        repeat (3) tick();
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.load", 32'(gcd_loadingValues), 32'd0);
        check("rst.timeout", 32'(timeout), 32'd0);
        check("rst.value1", 32'(gcd_value1), 32'd0);
        check("rst.value2", 32'(gcd_value2), 32'd0);
        check("rst.out_nibble", 32'(out_nibble), 32'd0);
        reset = 1'b0;
        #1;
        check("rst.in_ready_release", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset in the third WAIT cycle abandons the operation.
        load_cycles = 0;
        core_lat = 100;
        send(16'h1111, 16'h2222, 1'b0, "rstwait");
        repeat (3) tick();
        check("rstwait.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("rstwait.busy", 32'(busy), 32'd0);
        check("rstwait.out_valid", 32'(out_valid), 32'd0);
        check("rstwait.load", 32'(gcd_loadingValues), 32'd0);
        check("rstwait.in_ready_gated", 32'(in_ready), 32'd0);
        check("rstwait.value1", 32'(gcd_value1), 32'd0);
        reset = 1'b0;
        #1;
        check("rstwait.in_ready", 32'(in_ready), 32'd1);
        prev_to = 1'b0;
        v = '{16'h0048, 16'h0030, 3, 1'b0, -1, 16'h0018, 1'b0};
        run_op(v, "after_rst");

        // Back-to-back: next START follows the last taken nibble by 2*NIBS edges.
        v = '{16'h0100, 16'h0010, 2, 1'b0, -1, 16'h0010, 1'b0};
        run_op(v, "b2b_first");
        t_take = last_take_cyc;
        v = '{16'h0063, 16'h0024, 5, 1'b0, -1, 16'h0009, 1'b0};
        run_op(v, "b2b_second");
        check("b2b.start_gap", 32'(load_cyc - t_take), 32'(2 * NIBS));

        for (int i = 0; i < 25; i++) begin
            v.a     = 16'($urandom);
            v.b     = 16'($urandom);
            v.lat   = int'($urandom_range(0, 10));
            v.gap   = 1'($urandom_range(0, 1));
            v.stall = int'($urandom_range(0, 4));
            v.exp_to  = (v.lat >= TIMEOUT);
            v.exp_res = v.exp_to ? 16'hFFFF : gcd_ref(v.a, v.b);
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
